// File: rtl/pmbist_march_elem_engine_pkg.sv
// Shared types for the pmbist March-element engine: op commands, op descriptors,
// scan order and engine states.
package pmbist_march_elem_engine_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } t_op_cmd;

  typedef struct packed {
    logic    inv;
    t_op_cmd cmd;
  } t_march_op;

  typedef enum logic {
    XSCAN = 1'b0,
    YSCAN = 1'b1
  } t_scan_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } t_eng_state;

endpackage

// File: rtl/pmbist_march_elem_engine_if.sv
// Descriptor handshake between the microcode controller (master) and the
// March-element engine (slave).
interface pmbist_march_elem_engine_if
  import pmbist_march_elem_engine_pkg::*;
#(
  parameter int unsigned MAX_OPS = 4,
  parameter int unsigned D_WIDTH = 2
);
  logic                       i_elem_valid;
  logic                       o_elem_ready;
  logic                       i_elem_down;
  logic                       i_elem_yscan;
  logic [$clog2(MAX_OPS)-1:0] i_elem_nops;
  t_march_op [MAX_OPS-1:0]    i_elem_ops;
  logic [D_WIDTH-1:0]         i_dbg;

  modport master (
    output i_elem_valid, i_elem_down, i_elem_yscan, i_elem_nops, i_elem_ops, i_dbg,
    input  o_elem_ready
  );

  modport slave (
    input  i_elem_valid, i_elem_down, i_elem_yscan, i_elem_nops, i_elem_ops, i_dbg,
    output o_elem_ready
  );
endinterface

// File: rtl/pmbist_xy_addr_cnt.sv
// X/Y address counter: loads the start corner, then steps the fast coordinate,
// carrying into the slow one on wrap. Direction and scan order latch at load.
module pmbist_xy_addr_cnt
  import pmbist_march_elem_engine_pkg::*;
#(
  parameter int unsigned AX_WIDTH = 2,
  parameter int unsigned AY_WIDTH = 2
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic                i_down,
  input  logic                i_yscan,
  input  logic                i_step,
  output logic [AX_WIDTH-1:0] o_addr_x,
  output logic [AY_WIDTH-1:0] o_addr_y,
  output logic                o_last
);

  logic                down_q;
  t_scan_e             scan_q;
  logic [AX_WIDTH-1:0] x_nxt;
  logic [AY_WIDTH-1:0] y_nxt;
  logic                x_end;
  logic                y_end;

  always_comb begin
    x_nxt  = down_q ? o_addr_x - AX_WIDTH'(1) : o_addr_x + AX_WIDTH'(1);
    y_nxt  = down_q ? o_addr_y - AY_WIDTH'(1) : o_addr_y + AY_WIDTH'(1);
    x_end  = down_q ? (o_addr_x == '0) : (o_addr_x == '1);
    y_end  = down_q ? (o_addr_y == '0) : (o_addr_y == '1);
    o_last = x_end && y_end;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      down_q   <= 1'b0;
      scan_q   <= XSCAN;
      o_addr_x <= '0;
      o_addr_y <= '0;
    end else if (i_load) begin
      down_q   <= i_down;
      scan_q   <= i_yscan ? YSCAN : XSCAN;
      o_addr_x <= i_down ? '1 : '0;
      o_addr_y <= i_down ? '1 : '0;
    end else if (i_step) begin
      if (scan_q == XSCAN) begin
        o_addr_x <= x_nxt;
        if (x_end) o_addr_y <= y_nxt;
      end else begin
        o_addr_y <= y_nxt;
        if (y_end) o_addr_x <= x_nxt;
      end
    end
  end

endmodule

// File: rtl/pmbist_march_elem_engine.sv
// March-element executor: sweeps the X/Y space issuing the element's op list per
// address, then compares read data after RD_LATENCY with sticky fail capture.
module pmbist_march_elem_engine
  import pmbist_march_elem_engine_pkg::*;
#(
  parameter int unsigned AX_WIDTH   = 2,
  parameter int unsigned AY_WIDTH   = 2,
  parameter int unsigned D_WIDTH    = 2,
  parameter int unsigned MAX_OPS    = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        i_rst_n,
  pmbist_march_elem_engine_if.slave   elem,
  input  logic                        i_hold,
  input  logic                        i_clr_fail,
  input  logic [D_WIDTH-1:0]          i_rdata,
  output t_op_cmd                     o_op_cmd,
  output logic [AX_WIDTH-1:0]         o_addr_x,
  output logic [AY_WIDTH-1:0]         o_addr_y,
  output logic [D_WIDTH-1:0]          o_data,
  output logic                        o_elem_done,
  output logic                        o_fail,
  output logic [AX_WIDTH-1:0]         o_fail_addr_x,
  output logic [AY_WIDTH-1:0]         o_fail_addr_y,
  output logic [CNT_WIDTH-1:0]        o_fail_cnt
);

  localparam int unsigned NW = $clog2(MAX_OPS);
  localparam int unsigned DW = $clog2(RD_LATENCY + 1);

  typedef struct packed {
    logic                vld;
    logic [D_WIDTH-1:0]  exp;
    logic [AX_WIDTH-1:0] ax;
    logic [AY_WIDTH-1:0] ay;
  } t_rd_slot;

  t_eng_state              state_q, state_n;
  t_march_op [MAX_OPS-1:0] ops_q;
  logic [NW-1:0]           nops_q;
  logic [D_WIDTH-1:0]      dbg_q;
  logic [NW-1:0]           idx_q, idx_n;
  logic [DW-1:0]           dcnt_q, dcnt_n;
  t_op_cmd                 cmd_n;
  logic [D_WIDTH-1:0]      data_n;
  logic [AX_WIDTH-1:0]     ax_n;
  logic [AY_WIDTH-1:0]     ay_n;
  logic                    done_n;
  logic                    cnt_load, cnt_step, cnt_last;
  logic [AX_WIDTH-1:0]     cnt_x;
  logic [AY_WIDTH-1:0]     cnt_y;
  t_march_op               cur_op;
  t_rd_slot                pipe [RD_LATENCY];
  logic                    mismatch;

  pmbist_xy_addr_cnt #(
    .AX_WIDTH (AX_WIDTH),
    .AY_WIDTH (AY_WIDTH)
  ) u_addr_cnt (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_load   (cnt_load),
    .i_down   (elem.i_elem_down),
    .i_yscan  (elem.i_elem_yscan),
    .i_step   (cnt_step),
    .o_addr_x (cnt_x),
    .o_addr_y (cnt_y),
    .o_last   (cnt_last)
  );

  assign elem.o_elem_ready = (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_n;
  end

  // The counter holds the address of the next op to issue; outputs register it.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    dcnt_n   = dcnt_q;
    cmd_n    = OP_NOP;
    data_n   = o_data;
    ax_n     = o_addr_x;
    ay_n     = o_addr_y;
    done_n   = 1'b0;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    cur_op   = ops_q[idx_q];
    unique case (state_q)
      S_IDLE: begin
        if (elem.i_elem_valid) begin
          state_n  = S_RUN;
          idx_n    = '0;
          cnt_load = 1'b1;
        end
      end
      S_RUN: begin
        if (!i_hold) begin
          cmd_n  = cur_op.cmd;
          data_n = cur_op.inv ? ~dbg_q : dbg_q;
          ax_n   = cnt_x;
          ay_n   = cnt_y;
          if (idx_q < nops_q) begin
            idx_n = idx_q + NW'(1);
          end else begin
            idx_n = '0;
            if (cnt_last) begin
              state_n = S_DRAIN;
              dcnt_n  = '0;
            end else begin
              cnt_step = 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(RD_LATENCY)) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          dcnt_n = dcnt_q + DW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      idx_q       <= '0;
      dcnt_q      <= '0;
      ops_q       <= '0;
      nops_q      <= '0;
      dbg_q       <= '0;
      o_op_cmd    <= OP_NOP;
      o_addr_x    <= '0;
      o_addr_y    <= '0;
      o_data      <= '0;
      o_elem_done <= 1'b0;
    end else begin
      idx_q       <= idx_n;
      dcnt_q      <= dcnt_n;
      o_op_cmd    <= cmd_n;
      o_addr_x    <= ax_n;
      o_addr_y    <= ay_n;
      o_data      <= data_n;
      o_elem_done <= done_n;
      if (cnt_load) begin
        ops_q  <= elem.i_elem_ops;
        nops_q <= elem.i_elem_nops;
        dbg_q  <= elem.i_dbg;
      end
    end
  end

  assign mismatch = (state_q != S_IDLE) && pipe[RD_LATENCY-1].vld &&
                    (i_rdata != pipe[RD_LATENCY-1].exp);

  // A mismatch coinciding with a clear restarts the fail record from that mismatch.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
      o_fail        <= 1'b0;
      o_fail_cnt    <= '0;
      o_fail_addr_x <= '0;
      o_fail_addr_y <= '0;
    end else begin
      pipe[0].vld <= (o_op_cmd == OP_READ);
      pipe[0].exp <= o_data;
      pipe[0].ax  <= o_addr_x;
      pipe[0].ay  <= o_addr_y;
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      if (mismatch) begin
        o_fail <= 1'b1;
        if (!o_fail || i_clr_fail) begin
          o_fail_addr_x <= pipe[RD_LATENCY-1].ax;
          o_fail_addr_y <= pipe[RD_LATENCY-1].ay;
        end
        if (i_clr_fail)       o_fail_cnt <= CNT_WIDTH'(1);
        else if (!(&o_fail_cnt)) o_fail_cnt <= o_fail_cnt + CNT_WIDTH'(1);
      end else if (i_clr_fail) begin
        o_fail        <= 1'b0;
        o_fail_cnt    <= '0;
        o_fail_addr_x <= '0;
        o_fail_addr_y <= '0;
      end
    end
  end

endmodule
